// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing, colour width, counter widths and
// the {r,g,b} on/off table for the eight test-pattern bars.
package vga_pkg;
    localparam int H_ACTIVE_D = 640;
    localparam int H_FP_D = 16;
    localparam int H_SYNC_D = 96;
    localparam int H_BP_D = 48;
    localparam int V_ACTIVE_D = 480;
    localparam int V_FP_D = 10;
    localparam int V_SYNC_D = 2;
    localparam int V_BP_D = 33;
    localparam int COLOR_W_D = 8;
    localparam int HW = 11;
    localparam int VW = 10;
    // bar i sits at [3*i +: 3]: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [23:0] BAR_RGB = {3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111};
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        return BAR_RGB[3*idx +: 3];
    endfunction
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: DEPTH-stage, W-bit shift register advancing on adv; DEPTH 0 is a wire.
module vga_delay_line #(
    parameter int DEPTH = 1,
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    if (DEPTH == 0) begin : g_pass
        logic unused;
        assign unused = &{1'b0, clk, rst, adv};
        assign q = d;
    end else begin : g_sr
        logic [W-1:0] sr [DEPTH];
        always_ff @(posedge clk) begin
            if (rst) begin
                sr <= '{default: '0};
            end else if (adv) begin
                sr[0] <= d;
                for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
            end
        end
        assign q = sr[DEPTH-1];
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster engine; sync, bright and colour leave aligned PIX_LAT+1 ticks after request.
// Build macro VGA_TEST_PATTERN_EN adds pattern_sel and an eight-bar colour test pattern.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_FP = H_FP_D,
    parameter int H_SYNC = H_SYNC_D,
    parameter int H_BP = H_BP_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_FP = V_FP_D,
    parameter int V_SYNC = V_SYNC_D,
    parameter int V_BP = V_BP_D,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int COLOR_W = COLOR_W_D,
    parameter int PIX_LAT = 1
) (
    input  logic               clk_50m,
    input  logic               btn_rst,
    input  logic               enable,
`ifdef VGA_TEST_PATTERN_EN
    input  logic               pattern_sel,
`endif
    output logic               pix_en,
    output logic [HW-1:0]      pix_x,
    output logic [VW-1:0]      pix_y,
    output logic               pix_req,
    input  logic [COLOR_W-1:0] pix_r,
    input  logic [COLOR_W-1:0] pix_g,
    input  logic [COLOR_W-1:0] pix_b,
    output logic               vga_hsync,
    output logic               vga_vsync,
    output logic               bright,
    output logic [COLOR_W-1:0] vga_r,
    output logic [COLOR_W-1:0] vga_g,
    output logic [COLOR_W-1:0] vga_b,
    output logic               frame_start,
    output logic               line_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic clr, run;
    logic [DIV_W-1:0] div;
    logic hs_raw, vs_raw, req_raw, hs_d, vs_d, req_d, hs_q, vs_q;
    logic [COLOR_W-1:0] r_n, g_n, b_n;
    assign clr = btn_rst || !enable;
    // pix_en is registered so a reset or disable silences it on the very next cycle
    always_ff @(posedge clk_50m) begin
        if (clr) begin
            div <= '0;
            pix_en <= 1'b0;
            run <= 1'b0;
        end else begin
            div <= (div == DIV_W'(CLK_DIV-1)) ? '0 : div + 1'b1;
            pix_en <= div == DIV_W'(CLK_DIV-1);
            run <= 1'b1;
        end
    end
    always_ff @(posedge clk_50m) begin
        if (clr) begin
            pix_x <= '0;
            pix_y <= '0;
        end else if (pix_en) begin
            pix_x <= (pix_x == HW'(H_TOTAL-1)) ? '0 : pix_x + 1'b1;
            if (pix_x == HW'(H_TOTAL-1)) pix_y <= (pix_y == VW'(V_TOTAL-1)) ? '0 : pix_y + 1'b1;
        end
    end
    assign hs_raw = pix_x >= HW'(H_ACTIVE+H_FP) && pix_x < HW'(H_ACTIVE+H_FP+H_SYNC);
    assign vs_raw = pix_y >= VW'(V_ACTIVE+V_FP) && pix_y < VW'(V_ACTIVE+V_FP+V_SYNC);
    assign req_raw = pix_x < HW'(H_ACTIVE) && pix_y < VW'(V_ACTIVE);
    assign pix_req = run && req_raw;
    assign line_start = pix_en && pix_x == '0;
    assign frame_start = line_start && pix_y == '0;
`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE >= 8 ? H_ACTIVE / 8 : 1;
    logic [HW-1:0] x_d;
    logic [2:0] bar;
    vga_delay_line #(.DEPTH(PIX_LAT), .W(3 + HW)) u_dl (
        .clk(clk_50m), .rst(clr), .adv(pix_en),
        .d({hs_raw, vs_raw, req_raw, pix_x}), .q({hs_d, vs_d, req_d, x_d})
    );
    assign bar = bar_rgb(3'(x_d / HW'(BAR_W)));
    assign r_n = pattern_sel ? {COLOR_W{bar[2]}} : pix_r;
    assign g_n = pattern_sel ? {COLOR_W{bar[1]}} : pix_g;
    assign b_n = pattern_sel ? {COLOR_W{bar[0]}} : pix_b;
`else
    vga_delay_line #(.DEPTH(PIX_LAT), .W(3)) u_dl (
        .clk(clk_50m), .rst(clr), .adv(pix_en),
        .d({hs_raw, vs_raw, req_raw}), .q({hs_d, vs_d, req_d})
    );
    assign r_n = pix_r;
    assign g_n = pix_g;
    assign b_n = pix_b;
`endif
    always_ff @(posedge clk_50m) begin
        if (clr) begin
            hs_q <= 1'b0;
            vs_q <= 1'b0;
            bright <= 1'b0;
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
        end else if (pix_en) begin
            hs_q <= hs_d;
            vs_q <= vs_d;
            bright <= req_d;
            vga_r <= req_d ? r_n : '0;
            vga_g <= req_d ? g_n : '0;
            vga_b <= req_d ? b_n : '0;
        end
    end
    assign vga_hsync = hs_q ? HSYNC_POL : !HSYNC_POL;
    assign vga_vsync = vs_q ? VSYNC_POL : !VSYNC_POL;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: two small-geometry instances checked every cycle against a
// tick-count reference model, with randomized source colours, resets and disables.
module tb_vga_timing_gen;
    typedef struct packed {
        int d, ha, hf, hs, hb, va, vf, vs, vb, lat;
        bit hp, vp, pat;
    } cfg_t;
    typedef struct packed {
        logic pe;
        logic [10:0] x;
        logic [9:0] y;
        logic req, fs, ls, hs, vs, br;
        logic [7:0] r, g, b;
    } obs_t;
`ifdef VGA_TEST_PATTERN_EN
    localparam bit PAT_B = 1'b1;
`else
    localparam bit PAT_B = 1'b0;
`endif
    localparam cfg_t CA = '{d: 2, ha: 16, hf: 2, hs: 3, hb: 3, va: 6, vf: 1, vs: 2, vb: 1, lat: 2, hp: 0, vp: 0, pat: 0};
    localparam cfg_t CB = '{d: 1, ha: 8, hf: 1, hs: 2, hb: 1, va: 4, vf: 1, vs: 1, vb: 1, lat: 0, hp: 0, vp: 1, pat: PAT_B};
    localparam logic [2:0] BARS [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};

    logic clk = 1'b0;
    logic btn_rst, enable;
    logic [7:0] src_r [2], src_g [2], src_b [2];
    logic a_pe, a_req, a_hs, a_vs, a_br, a_fs, a_ls, b_pe, b_req, b_hs, b_vs, b_br, b_fs, b_ls;
    logic [10:0] a_x, b_x;
    logic [9:0] a_y, b_y;
    logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b;
    obs_t got_a, got_b;
    bit run;
    int m, cmp, err;
    int n [2];
    bit tick_prev [2];
    logic [7:0] gq [2][16], bq [2][16];

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CLK_DIV(CA.d), .H_ACTIVE(CA.ha), .H_FP(CA.hf), .H_SYNC(CA.hs), .H_BP(CA.hb),
        .V_ACTIVE(CA.va), .V_FP(CA.vf), .V_SYNC(CA.vs), .V_BP(CA.vb),
        .HSYNC_POL(CA.hp), .VSYNC_POL(CA.vp), .COLOR_W(8), .PIX_LAT(CA.lat)
    ) dut_a (
        .clk_50m(clk), .btn_rst(btn_rst), .enable(enable),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_sel(1'b0),
`endif
        .pix_en(a_pe), .pix_x(a_x), .pix_y(a_y), .pix_req(a_req),
        .pix_r(src_r[0]), .pix_g(src_g[0]), .pix_b(src_b[0]),
        .vga_hsync(a_hs), .vga_vsync(a_vs), .bright(a_br),
        .vga_r(a_r), .vga_g(a_g), .vga_b(a_b), .frame_start(a_fs), .line_start(a_ls)
    );
    vga_timing_gen #(
        .CLK_DIV(CB.d), .H_ACTIVE(CB.ha), .H_FP(CB.hf), .H_SYNC(CB.hs), .H_BP(CB.hb),
        .V_ACTIVE(CB.va), .V_FP(CB.vf), .V_SYNC(CB.vs), .V_BP(CB.vb),
        .HSYNC_POL(CB.hp), .VSYNC_POL(CB.vp), .COLOR_W(8), .PIX_LAT(CB.lat)
    ) dut_b (
        .clk_50m(clk), .btn_rst(btn_rst), .enable(enable),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_sel(1'b1),
`endif
        .pix_en(b_pe), .pix_x(b_x), .pix_y(b_y), .pix_req(b_req),
        .pix_r(src_r[1]), .pix_g(src_g[1]), .pix_b(src_b[1]),
        .vga_hsync(b_hs), .vga_vsync(b_vs), .bright(b_br),
        .vga_r(b_r), .vga_g(b_g), .vga_b(b_b), .frame_start(b_fs), .line_start(b_ls)
    );
    assign got_a = {a_pe, a_x, a_y, a_req, a_fs, a_ls, a_hs, a_vs, a_br, a_r, a_g, a_b};
    assign got_b = {b_pe, b_x, b_y, b_req, b_fs, b_ls, b_hs, b_vs, b_br, b_r, b_g, b_b};

    function automatic cfg_t cfg(input int i);
        return i == 0 ? CA : CB;
    endfunction

    // Expected outputs from the count of pixel ticks completed since release:
    // requests follow tick n, outputs show the request made lat+1 ticks earlier.
    function automatic obs_t model(input int i);
        cfg_t c = cfg(i);
        int ht = c.ha + c.hf + c.hs + c.hb;
        int vt = c.va + c.vf + c.vs + c.vb;
        int j = n[i] - 1 - c.lat;
        int jx, jy;
        logic [2:0] bar;
        obs_t o = '0;
        o.hs = !c.hp;
        o.vs = !c.vp;
        if (run) begin
            o.pe = (m % c.d) == 0;
            o.x = 11'(n[i] % ht);
            o.y = 10'((n[i] / ht) % vt);
            o.req = int'(o.x) < c.ha && int'(o.y) < c.va;
            o.ls = o.pe && o.x == 0;
            o.fs = o.ls && o.y == 0;
            if (j >= 0) begin
                jx = j % ht;
                jy = (j / ht) % vt;
                o.hs = (jx >= c.ha + c.hf && jx < c.ha + c.hf + c.hs) ? c.hp : !c.hp;
                o.vs = (jy >= c.va + c.vf && jy < c.va + c.vf + c.vs) ? c.vp : !c.vp;
                o.br = jx < c.ha && jy < c.va;
                if (o.br && c.pat) begin
                    bar = BARS[jx / (c.ha / 8)];
                    o.r = bar[2] ? 8'hFF : 8'h00;
                    o.g = bar[1] ? 8'hFF : 8'h00;
                    o.b = bar[0] ? 8'hFF : 8'h00;
                end else if (o.br) begin
                    o.r = 8'(jx);
                    o.g = gq[i][j % 16];
                    o.b = bq[i][j % 16];
                end
            end
        end
        return o;
    endfunction

    task automatic check(input int i, input string tag, input logic [31:0] gv, input logic [31:0] ev);
        cmp++;
        assert (gv === ev) else begin
            err++;
            $error("FAIL %s inst%0d t=%0t got=%h exp=%h", tag, i, $time, gv, ev);
        end
    endtask

    task automatic step(input bit r, input bit e);
        obs_t ex, gt;
        cfg_t c;
        int ht, k;
        btn_rst = r;
        enable = e;
        @(posedge clk);
        if (r || !e) begin
            run = 0;
            m = 0;
            n[0] = 0;
            n[1] = 0;
        end else begin
            run = 1;
            m++;
            for (int i = 0; i < 2; i++) if (tick_prev[i]) n[i]++;
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            c = cfg(i);
            ht = c.ha + c.hf + c.hs + c.hb;
            ex = model(i);
            gt = i ? got_b : got_a;
            check(i, "timing", 32'({gt.pe, gt.x, gt.y, gt.req, gt.fs, gt.ls}), 32'({ex.pe, ex.x, ex.y, ex.req, ex.fs, ex.ls}));
            check(i, "sync", 32'({gt.hs, gt.vs}), 32'({ex.hs, ex.vs}));
            check(i, "video", 32'({gt.br, gt.r, gt.g, gt.b}), 32'({ex.br, ex.r, ex.g, ex.b}));
            tick_prev[i] = ex.pe;
            // pixel source: answers request k on the tick lat ticks later, noise otherwise
            k = n[i] - c.lat;
            if (ex.pe) begin
                gq[i][n[i] % 16] = 8'($urandom);
                bq[i][n[i] % 16] = 8'($urandom);
            end
            if (ex.pe && k >= 0) begin
                src_r[i] = 8'(k % ht);
                src_g[i] = gq[i][k % 16];
                src_b[i] = bq[i][k % 16];
            end else begin
                src_r[i] = 8'($urandom);
                src_g[i] = 8'($urandom);
                src_b[i] = 8'($urandom);
            end
        end
    endtask

    initial begin
        cmp = 0;
        err = 0;
        for (int i = 0; i < 2; i++) begin
            src_r[i] = 8'hFF;
            src_g[i] = 8'hFF;
            src_b[i] = 8'hFF;
            tick_prev[i] = 0;
        end
        repeat (5) step(1, 1);
        repeat (3) step(0, 0);
        repeat (1200) step(0, 1);
        step(1, 1);
        for (int k = 0; k < 400 && n[0] != 3 * 24 + 5; k++) step(0, 1);
        repeat (2) step(1, 1);
        repeat (800) step(0, 1);
        repeat (4) step(0, 0);
        repeat (800) step(0, 1);
        repeat (3000) step($urandom_range(199) == 0, $urandom_range(149) != 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster engine that replaces the fixed 640x480 BitGen timing path. It divides `clk_50m` into a pixel-clock enable and generates horizontal/vertical counters, sync and blanking. It requests pixel colour from an external pixel source with a configurable read latency. Output sync, `bright` and colour are realigned so they leave the block on the same pixel tick. It sits between the display framebuffer/sprite logic and the VGA DAC pins.

## Interface
- `CLK_DIV`, 2: `clk_50m` cycles per pixel, 1..8.
- `H_ACTIVE`, `H_FP`, `H_SYNC`, `H_BP`: 640, 16, 96, 48 pixels.
- `V_ACTIVE`, `V_FP`, `V_SYNC`, `V_BP`: 480, 10, 2, 33 lines.
- `HSYNC_POL`, `VSYNC_POL`, 0: active level of each sync.
- `COLOR_W`, 8: bits per colour channel.
- `PIX_LAT`, 1: pixel-source read latency in pixel ticks, 0..4.
- `clk_50m`  in  1  system clock; the only clock.
- `btn_rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  low: counters cleared and held, outputs idle.
- `pix_en`  out  1  one-cycle pixel tick (replaces `clk_25MHz`).
- `pix_x`  out  11  requested column.
- `pix_y`  out  10  requested row.
- `pix_req`  out  1  high when (`pix_x`, `pix_y`) is in the active area.
- `pix_r`, `pix_g`, `pix_b`  in  COLOR_W each  source colour, valid PIX_LAT ticks after the request.
- `vga_hsync`, `vga_vsync`  out  1  sync outputs.
- `bright`  out  1  active-video flag, aligned with colour.
- `vga_r`, `vga_g`, `vga_b`  out  COLOR_W each  output colour; zero when not `bright`.
- `frame_start`  out  1  one-cycle pulse, coincident with `pix_en`, at h=0, v=0 of the request stage.
- `line_start`  out  1  one-cycle pulse, coincident with `pix_en`, at h=0 of every line.

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Divider: counts 0..CLK_DIV-1. `pix_en` is high when the divider equals CLK_DIV-1. With CLK_DIV=1, `pix_en` is constantly high.
- Counters: `pix_x` increments on `pix_en`. At H_TOTAL-1 it wraps to 0 and `pix_y` increments. `pix_y` wraps to 0 after V_TOTAL-1.
- Raw timing, per request-stage counter value:
  - hsync active for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync active for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
  - `pix_req` = x<H_ACTIVE && y<V_ACTIVE.
- Alignment: raw hsync, vsync and `pix_req` pass through a PIX_LAT-deep delay line that advances only on `pix_en`. The output register then samples the delayed flags and `pix_r/g/b` on `pix_en`.
- Colour: when the delayed `pix_req` is 0, colour is forced to 0 regardless of `pix_r/g/b`.
- Sync polarity: each output sync equals its POL value when active and the inverse when inactive.
- Reset (`btn_rst`=1 at a clock edge) and `enable`=0 have identical effects:
  - divider, counters and delay line are cleared;
  - `pix_en`, `pix_req`, `bright`, `frame_start`, `line_start` and colour go to 0;
  - both syncs go to their inactive level.
- Reset mid-frame abandons the frame. The first `pix_en` after release begins a new frame at (0,0), with `frame_start`.
- Reset takes priority over `enable`.

## Timing
- Request-to-output latency: PIX_LAT+1 pixel ticks, i.e. (PIX_LAT+1)*CLK_DIV `clk_50m` cycles.
- The first `pix_en` after reset release occurs CLK_DIV cycles after release.
- Output registers change only on cycles where `pix_en`=1.
- hsync period: H_TOTAL ticks. vsync period: H_TOTAL*V_TOTAL ticks.
- Output vsync edges coincide with output hsync-period boundaries (x=0 of the delayed stream).

## Configuration
- Macro: `VGA_TEST_PATTERN_EN`.
- Defined:
  - adds input `pattern_sel` (1 bit);
  - when it is 1, `pix_r/g/b` are ignored and the output shows 8 vertical colour bars, each H_ACTIVE/8 wide, in the order white, yellow, cyan, green, magenta, red, blue, black (full-scale channels);
  - the pattern is generated from the delayed column, so alignment is unchanged.
- Undefined: no `pattern_sel` port; colour always comes from the pixel source.

## Structure
- `vga_pkg`:
  - default 640x480@60 timing constants;
  - COLOR_W default;
  - counter widths;
  - test-pattern bar colour constants.
- Sub-module `vga_delay_line`: a parametrised-depth, parametrised-width shift register that advances on an enable. Depth 0 is a passthrough. It is used for the sync, `pix_req` and column alignment.

## Test plan
- Reset and idle:
  - stimulus: hold `btn_rst` high for 5 cycles, then 3 cycles with `enable`=0;
  - required: all colour 0, `bright`=0, `vga_hsync`=`vga_vsync`=1 (POL=0), no `pix_en`.
- Default geometry, CLK_DIV=2:
  - hsync period 1600 `clk_50m` cycles, low for 192 cycles;
  - `bright` high for 640 ticks per active line;
  - vsync period 525 lines, low for 2 lines.
- Latency, PIX_LAT=2:
  - stimulus: the source returns `pix_r` = `pix_x[7:0]` after 2 ticks;
  - required: `vga_r` equals the column index of each `bright` pixel, and the first `bright` tick shows 0.
- Blanking:
  - stimulus: `pix_r/g/b` = FF constantly;
  - required: colour is 0 on every tick with `bright`=0, including front and back porch.
- Mid-frame reset:
  - stimulus: assert `btn_rst` at line 200, column 300;
  - required: outputs go idle the next cycle, and the next `frame_start` arrives CLK_DIV cycles after release.
- Small config, CLK_DIV=1, H 8/1/2/1, V 4/1/1/1, PIX_LAT=0, with `VGA_TEST_PATTERN_EN` and `pattern_sel`=1:
  - `pix_en` constant;
  - hsync period 12 cycles;
  - bars are 1 pixel wide, in white to black order.
